// File: rtl/rew_seed_expander.sv
// REW seed expander: turns each (IV, BID) seed into ChunksPerBkt AES counter-mode input blocks.
// Optional seed counter port OutSeedCount is built when REW_SEED_STATS_EN is defined.
module rew_seed_expander #(
  parameter int unsigned AESEntropy = 64,
  parameter int unsigned ORAML = 20,
  parameter int unsigned AESWidth = 128,
  parameter int unsigned ChunksPerBkt = 8,
  localparam int unsigned ChunkIdxWidth = (ChunksPerBkt > 1) ? $clog2(ChunksPerBkt) : 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [AESEntropy-1:0]    InIV,
  input  logic [ORAML:0]           InBID,
  input  logic                     InValid,
  output logic                     InReady,
  output logic [AESWidth-1:0]      OutAESIn,
  output logic                     OutWrite,
  output logic [ChunkIdxWidth-1:0] OutChunk,
  output logic                     OutLast,
  output logic                     OutValid,
  input  logic                     OutReady
`ifdef REW_SEED_STATS_EN
  ,
  output logic [31:0]              OutSeedCount
`endif
);

  localparam int unsigned LvlWidth = (ORAML > 0) ? $clog2(ORAML + 1) : 1;
  localparam logic [LvlWidth-1:0] LvlMax = LvlWidth'(ORAML);
  localparam logic [ChunkIdxWidth-1:0] LastChunk = ChunkIdxWidth'(ChunksPerBkt - 1);

  if (AESEntropy + ORAML + 1 + ChunkIdxWidth > AESWidth) begin : g_width_err
    $error("rew_seed_expander: IV, BID and chunk index do not fit in AESWidth");
  end
  if (ChunksPerBkt < 1) begin : g_chunks_err
    $error("rew_seed_expander: ChunksPerBkt must be at least 1");
  end

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e                   state_q, state_d;
  logic [AESEntropy-1:0]    iv_q, iv_d;
  logic [ORAML:0]           bid_q, bid_d;
  logic                     write_q, write_d;
  logic [ChunkIdxWidth-1:0] chunk_q, chunk_d;
  logic                     last_q, last_d;
  logic [LvlWidth-1:0]      lvl_cnt_q, lvl_cnt_d;
  logic                     dir_next_q, dir_next_d;
  logic                     accept, xfer;

  assign OutValid = (state_q == StEmit);
  // last_q is only ever set while emitting, so it doubles as "current block is last".
  assign InReady  = (state_q == StIdle) || (last_q && OutReady);
  assign accept   = InValid && InReady;
  assign xfer     = OutValid && OutReady;
  assign OutWrite = write_q;
  assign OutChunk = chunk_q;
  assign OutLast  = last_q;

  always_comb begin
    OutAESIn = '0;
    OutAESIn[ChunkIdxWidth-1:0] = chunk_q;
    OutAESIn[ChunkIdxWidth +: ORAML + 1] = bid_q;
    OutAESIn[ChunkIdxWidth + ORAML + 1 +: AESEntropy] = iv_q;
  end

  always_comb begin
    state_d    = state_q;
    iv_d       = iv_q;
    bid_d      = bid_q;
    write_d    = write_q;
    chunk_d    = chunk_q;
    lvl_cnt_d  = lvl_cnt_q;
    dir_next_d = dir_next_q;
    if (accept) begin
      // Covers both the idle accept and the back-to-back accept on the last block.
      state_d = StEmit;
      iv_d    = InIV;
      bid_d   = InBID;
      write_d = dir_next_q;
      chunk_d = '0;
      if (lvl_cnt_q == LvlMax) begin
        lvl_cnt_d  = '0;
        dir_next_d = ~dir_next_q;
      end else begin
        lvl_cnt_d = lvl_cnt_q + LvlWidth'(1);
      end
    end else if (xfer) begin
      if (last_q) begin
        state_d = StIdle;
      end else begin
        chunk_d = chunk_q + ChunkIdxWidth'(1);
      end
    end
    last_d = (state_d == StEmit) && (chunk_d == LastChunk);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= StIdle;
      iv_q       <= '0;
      bid_q      <= '0;
      write_q    <= 1'b0;
      chunk_q    <= '0;
      last_q     <= 1'b0;
      lvl_cnt_q  <= '0;
      dir_next_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      iv_q       <= iv_d;
      bid_q      <= bid_d;
      write_q    <= write_d;
      chunk_q    <= chunk_d;
      last_q     <= last_d;
      lvl_cnt_q  <= lvl_cnt_d;
      dir_next_q <= dir_next_d;
    end
  end

`ifdef REW_SEED_STATS_EN
  logic [31:0] seed_count_q, seed_count_d;

  always_comb begin
    seed_count_d = seed_count_q;
    if (accept) begin
      seed_count_d = seed_count_q + 32'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      seed_count_q <= '0;
    end else begin
      seed_count_q <= seed_count_d;
    end
  end

  assign OutSeedCount = seed_count_q;
`else
  // No seed statistics in this build.
`endif

endmodule

// File: tb/tb_rew_seed_expander.sv
// Self-checking bench for rew_seed_expander: random seeds against a queue-of-blocks reference model.
module tb_rew_seed_expander;

  localparam int unsigned AESEntropy = 64;
  localparam int unsigned ORAML = 2;
  localparam int unsigned AESWidth = 128;
  localparam int unsigned CPB = 8;
  localparam int unsigned CIW = 3;

  logic                  Clock;
  logic                  Reset;
  logic [AESEntropy-1:0] InIV;
  logic [ORAML:0]        InBID;
  logic                  InValid;
  logic                  InReady;
  logic [AESWidth-1:0]   OutAESIn;
  logic                  OutWrite;
  logic [CIW-1:0]        OutChunk;
  logic                  OutLast;
  logic                  OutValid;
  logic                  OutReady;
`ifdef REW_SEED_STATS_EN
  logic [31:0]           seed_count;
`endif

  rew_seed_expander #(
    .AESEntropy  (AESEntropy),
    .ORAML       (ORAML),
    .AESWidth    (AESWidth),
    .ChunksPerBkt(CPB)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .InIV    (InIV),
    .InBID   (InBID),
    .InValid (InValid),
    .InReady (InReady),
    .OutAESIn(OutAESIn),
    .OutWrite(OutWrite),
    .OutChunk(OutChunk),
    .OutLast (OutLast),
    .OutValid(OutValid),
    .OutReady(OutReady)
`ifdef REW_SEED_STATS_EN
    ,
    .OutSeedCount(seed_count)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [127:0] aes;
    logic         write;
    logic [2:0]   chunk;
    logic         last;
  } blk_t;

  blk_t q[$];
  int   n_seeds;
  int   checks;
  int   failures;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s: got timeout expected completion", tag);
  endtask

  // Each accepted seed contributes CPB blocks; direction flips every ORAML+1 seeds.
  task automatic push_seed(input logic [AESEntropy-1:0] iv, input logic [ORAML:0] bid);
    for (int k = 0; k < CPB; k++) begin
      blk_t b;
      b.aes = (128'(iv) << (CIW + ORAML + 1)) | (128'(bid) << CIW) | 128'(k);
      b.write = ((n_seeds / (ORAML + 1)) % 2) == 1;
      b.chunk = 3'(k);
      b.last = (k == CPB - 1);
      q.push_back(b);
    end
    n_seeds++;
  endtask

  task automatic cycle();
    logic exp_valid;
    logic exp_ready;
    @(negedge Clock);
    exp_valid = (q.size() != 0);
    exp_ready = (q.size() == 0) || (q.size() == 1 && OutReady);
    chk("out_valid", 128'(OutValid), 128'(exp_valid));
    chk("in_ready", 128'(InReady), 128'(exp_ready));
    if (exp_valid) begin
      chk("out_aes_in", OutAESIn, q[0].aes);
      chk("out_write", 128'(OutWrite), 128'(q[0].write));
      chk("out_chunk", 128'(OutChunk), 128'(q[0].chunk));
      chk("out_last", 128'(OutLast), 128'(q[0].last));
    end
`ifdef REW_SEED_STATS_EN
    chk("seed_count", 128'(seed_count), 128'(n_seeds));
`endif
    if (exp_valid && OutReady) void'(q.pop_front());
    if (InValid && exp_ready) push_seed(InIV, InBID);
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    InValid = 1'b0;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    q.delete();
    n_seeds = 0;
    @(negedge Clock);
    chk("rst_out_valid", 128'(OutValid), 128'(0));
    chk("rst_in_ready", 128'(InReady), 128'(1));
    chk("rst_out_chunk", 128'(OutChunk), 128'(0));
    chk("rst_out_last", 128'(OutLast), 128'(0));
    chk("rst_out_write", 128'(OutWrite), 128'(0));
    chk("rst_out_aes_in", OutAESIn, 128'(0));
`ifdef REW_SEED_STATS_EN
    chk("rst_seed_count", 128'(seed_count), 128'(0));
`endif
    @(posedge Clock);
    #1;
  endtask

  task automatic randomize_seed();
    InIV = {$urandom, $urandom};
    InBID = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    int guard;
    InValid = 1'b0;
    OutReady = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      cycle();
      guard++;
    end
    if (q.size() != 0) timeout("drain");
    cycle();
  endtask

  initial begin
    int guard;
    checks = 0;
    failures = 0;
    n_seeds = 0;
    Reset = 1'b1;
    InValid = 1'b0;
    InIV = '0;
    InBID = '0;
    OutReady = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    do_reset();

    // Single directed seed, then back to idle.
    InIV = 64'h5;
    InBID = 3'h3;
    InValid = 1'b1;
    cycle();
    drain();

    // Twenty back-to-back seeds with continuous readiness.
    InValid = 1'b1;
    guard = 0;
    while (n_seeds < 21 && guard < 400) begin
      randomize_seed();
      cycle();
      guard++;
    end
    if (n_seeds < 21) timeout("back_to_back");
    drain();

    // Stall at chunk 3 for five cycles.
    randomize_seed();
    InValid = 1'b1;
    cycle();
    InValid = 1'b0;
    guard = 0;
    while (!(q.size() != 0 && q[0].chunk == 3) && guard < 20) begin
      cycle();
      guard++;
    end
    if (guard >= 20) timeout("reach_chunk3");
    OutReady = 1'b0;
    repeat (5) cycle();
    OutReady = 1'b1;
    drain();

    // Random handshake mix.
    for (int i = 0; i < 300; i++) begin
      randomize_seed();
      InValid = 1'($urandom_range(0, 1));
      OutReady = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    // Reset in the middle of a write seed.
    do_reset();
    InValid = 1'b1;
    guard = 0;
    while (n_seeds < ORAML + 2 && guard < 100) begin
      randomize_seed();
      cycle();
      guard++;
    end
    InValid = 1'b0;
    guard = 0;
    while (!(q.size() != 0 && q[0].write && q[0].chunk == 4) && guard < 100) begin
      cycle();
      guard++;
    end
    if (guard >= 100) timeout("reach_write_chunk4");
    do_reset();
    randomize_seed();
    InValid = 1'b1;
    cycle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rew_seed_expander.md
Name: rew_seed_expander

Overview:
- Sits directly downstream of the REW Gentry seed generator and consumes its per-bucket (IV, BID) seed stream.
- Expands each seed into ChunksPerBkt AES counter-mode input blocks, one per bucket chunk, for the AES pad core.
- Tags each block with its read/write path direction and a last-chunk flag.
- Provides a registered valid/ready handshake on both sides, with no bubbles between consecutive seeds.

Parameters:
- AESEntropy, 64, IV width in bits.
- ORAML, 20, tree depth; BID width is ORAML+1.
- AESWidth, 128, AES input block width.
- ChunksPerBkt, 8, number of chunks per bucket, >=1.
- ChunkIdxWidth, max(1, clog2(ChunksPerBkt)), derived; not overridden.

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- InIV  in  AESEntropy  seed IV from the seed generator
- InBID  in  ORAML+1  bucket ID from the seed generator
- InValid  in  1  seed valid
- InReady  out  1  seed accepted when InValid && InReady
- OutAESIn  out  AESWidth  AES input block
- OutWrite  out  1  0 = read-path (decrypt) seed, 1 = write-path (encrypt) seed
- OutChunk  out  ChunkIdxWidth  chunk index of the current block
- OutLast  out  1  current block is chunk ChunksPerBkt-1
- OutValid  out  1  output block valid
- OutReady  in  1  downstream accepts when OutValid && OutReady
- OutSeedCount  out  32  present only with REW_SEED_STATS_EN

Behaviour:
- Reset is Reset, synchronous, active-high; clock is Clock.
- Reset state:
  - State IDLE; OutValid=0, InReady=1.
  - OutChunk=0, OutLast=0, OutWrite=0, OutAESIn=0.
  - Level counter LvlCnt=0, direction register DirNext=0 (read first).
- States:
  - IDLE: InReady=1, OutValid=0.
  - EMIT: OutValid=1.
- Seed accept (InValid && InReady) latches the following, and the state becomes EMIT on the next cycle (latency 1):
  - InIV and InBID.
  - DirNext into OutWrite.
  - OutChunk=0.
- Direction tracking, applied on every accept:
  - If LvlCnt==ORAML: LvlCnt<=0 and DirNext<=~DirNext.
  - Otherwise: LvlCnt<=LvlCnt+1.
  - Result: ORAML+1 read seeds, then ORAML+1 write seeds, alternating forever, matching the generator's path order.
- OutAESIn = {zero-fill, IV, BID, OutChunk}.
  - Chunk index occupies the LSBs, then BID, then IV; the remaining MSBs are 0.
  - Elaboration error if AESEntropy+ORAML+1+ChunkIdxWidth > AESWidth.
- Block transfer (OutValid && OutReady):
  - If not OutLast: OutChunk increments.
  - If OutLast and InValid: the new seed is latched in the same cycle, OutChunk=0, state stays EMIT (back-to-back, no bubble).
  - If OutLast and !InValid: state goes to IDLE.
- InReady = (state==IDLE) || (OutLast && OutReady). Combinational from registered state and OutReady; no path from InValid to InReady.
- OutLast = (OutChunk == ChunksPerBkt-1). With ChunksPerBkt=1, every block is last and OutChunk stays 0.
- While OutValid && !OutReady, all outputs hold stable.
- Throughput: one block per cycle under continuous OutReady; one seed per ChunksPerBkt cycles.
- Reset mid-EMIT discards the in-flight seed; LvlCnt and direction restart at read.

Optional Feature:
- Macro REW_SEED_STATS_EN.
- Defined:
  - OutSeedCount port exists.
  - 32-bit counter, reset 0, increments on each seed accept.
  - Wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then single seed IV=0x5, BID=0x3 with ChunksPerBkt=8 and OutReady=1 -> eight blocks on consecutive cycles, OutChunk 0..7, OutLast only on chunk 7, OutWrite=0, OutAESIn[2:0]=chunk, BID field=0x3, IV field=0x5; then IDLE.
- Continuous InValid and OutReady, 20 seeds -> no idle cycle between seeds; InReady high only on OutLast cycles after the first accept.
- ORAML=2, 12 seeds -> OutWrite pattern 0,0,0,1,1,1,0,0,0,1,1,1.
- OutReady held low for 5 cycles at chunk 3 -> OutAESIn, OutChunk, OutValid stable; InReady=0; resumes at chunk 3.
- Reset asserted during chunk 4 of a write seed -> next cycle OutValid=0, InReady=1; next seed emits chunk 0 with OutWrite=0.
- With REW_SEED_STATS_EN, 3 seeds -> OutSeedCount=3; Reset -> 0.
